// File: rtl/uart_pkt_rx_pkg.sv
// Shared definitions for the UART packet framing receiver: FSM states, default sync byte,
// and the frame checksum rule.
package uart_pkt_rx_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StLen,
    StPayload,
    StCheck,
    StSend
  } pkt_state_e;

  // Shared with the transmit-side framer so both ends agree on frame start.
  localparam logic [7:0] DefaultSync = 8'hA5;

  // Frame is good when LEN + payload + CHK wraps to zero; sum already holds LEN + payload.
  function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk);
    logic [7:0] total;
    total = sum + chk;
    return (total == 8'h00);
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer for uart_pkt_rx: MAX_LEN x 8 register array, one write port and one
// asynchronous read port. Contents are deliberately not reset.
module uart_pkt_buf #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned IW      = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet framer behind uart_rx: hunts for SYNC, checks LEN and checksum with an inter-byte
// timeout, and releases only verified payloads as a valid/ready byte stream with a last flag.
module uart_pkt_rx
  import uart_pkt_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SYNC    = DefaultSync,
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_vld,
  output logic [7:0] o_data,
  output logic       o_vld,
  output logic       o_last,
  input  logic       i_rdy,
  output logic       o_pkt_err,
  output logic       o_drop
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  pkt_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_wr;
  logic [CW-1:0] r_rd;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_data;
  logic          r_vld;
  logic          r_last;
  logic          r_err;
  logic          r_drop;

  logic          w_hs;
  logic          w_we;
  logic          w_tmo_hit;
  logic          w_len_ok;
  logic          w_last_next;
  logic [CW-1:0] w_rd_next;
  logic [IW-1:0] w_raddr;
  logic [7:0]    w_rdata;

  assign w_hs        = r_vld & i_rdy;
  assign w_we        = (r_state == StPayload) & i_data_vld;
  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
  assign w_len_ok    = (i_data != 8'h00) && (i_data <= MaxLenB);
  assign w_rd_next   = r_rd + CW'(1);
  assign w_last_next = (w_rd_next == (r_cnt - CW'(1)));

  // Outside SEND the read port points at entry 0 so the first byte is ready on CHK accept.
  always_comb begin
    w_raddr = '0;
    if (r_state == StSend) begin
      w_raddr = w_rd_next[IW-1:0];
    end
  end

  uart_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .IW      (IW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr[IW-1:0]),
    .i_wdata (i_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StHunt;
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_sum   <= '0;
      r_tmo   <= '0;
      r_data  <= 8'h00;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_drop <= 1'b0;
      if (i_data_vld || (r_state == StHunt) || (r_state == StSend)) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end

      unique case (r_state)
        StHunt: begin
          if (i_data_vld && (i_data == SYNC)) begin
            r_state <= StLen;
          end
        end
        StLen: begin
          if (i_data_vld) begin
            if (w_len_ok) begin
              r_state <= StPayload;
              r_sum   <= i_data;
              r_cnt   <= i_data[CW-1:0];
              r_wr    <= '0;
            end else begin
              r_state <= StHunt;
              r_err   <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state <= StHunt;
            r_err   <= 1'b1;
          end
        end
        StPayload: begin
          if (i_data_vld) begin
            r_sum <= r_sum + i_data;
            r_wr  <= r_wr + CW'(1);
            if (r_wr == (r_cnt - CW'(1))) begin
              r_state <= StCheck;
            end
          end else if (w_tmo_hit) begin
            r_state <= StHunt;
            r_err   <= 1'b1;
          end
        end
        StCheck: begin
          if (i_data_vld) begin
            if (chk_ok(r_sum, i_data)) begin
              r_state <= StSend;
              r_rd    <= '0;
              r_vld   <= 1'b1;
              r_data  <= w_rdata;
              r_last  <= (r_cnt == CW'(1));
            end else begin
              r_state <= StHunt;
              r_err   <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state <= StHunt;
            r_err   <= 1'b1;
          end
        end
        StSend: begin
          // No backpressure upstream: bytes arriving now are lost, and reported.
          if (i_data_vld) begin
            r_drop <= 1'b1;
          end
          if (w_hs) begin
            if (r_last) begin
              r_state <= StHunt;
              r_vld   <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_rd   <= w_rd_next;
              r_data <= w_rdata;
              r_last <= w_last_next;
            end
          end
        end
        default: r_state <= StHunt;
      endcase
    end
  end

  assign o_data    = r_data;
  assign o_vld     = r_vld;
  assign o_last    = r_last;
  assign o_pkt_err = r_err;
  assign o_drop    = r_drop;

endmodule
